div_core_arbiter: RTL and testbench

//  Shares one unsigned div_core between NUM_REQ requesters (e.g. integer div unit, FP/sqrt helper).

---
 rtl/div_core_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_div_core_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_core_arbiter.sv
// ---------------------------------------------------------------------------
// div_core_arbiter
//
// Shares a single unsigned div_core between NUM_REQ requesters. Requests are
// granted round-robin, the winner's operands are captured and launched into
// the core with a one-cycle start pulse, and the result is held for the
// winner until that requester acknowledges it. One division in flight.
//
// Optional feature (macro DIV_ARB_REUSE_EN): a one-entry result cache. An
// accepted request whose dividend/divisor match the last completed division
// is answered from the cache (IDLE -> RESP, rsp_valid one cycle after the
// accept, no core launch). With the macro undefined, every accept launches
// the core and no cache registers exist.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      per-requester handshake, ready is one-hot in IDLE
//   req_dividend/divisor     packed operands, slice i = requester i
//   req_*_clz, req_divisor_is_zero   pre-processed side info, passed through
//   rsp_valid/rsp_ack        one-hot result valid to the winner, winner's ack
//   rsp_quotient/remainder   registered result
//   core_start               one-cycle launch pulse to div_core
//   core_dividend/divisor, core_*_clz, core_divisor_is_zero  registered operands
//   core_done, core_quotient/remainder  div_core completion and results
//   busy                     arbiter is not idle
// ---------------------------------------------------------------------------
module div_core_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int CLZ_W      = $clog2(DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
  input  logic [NUM_REQ*CLZ_W-1:0]    req_dividend_clz,
  input  logic [NUM_REQ*CLZ_W-1:0]    req_divisor_clz,
  input  logic [NUM_REQ-1:0]          req_divisor_is_zero,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ack,
  output logic [DATA_WIDTH-1:0]       rsp_quotient,
  output logic [DATA_WIDTH-1:0]       rsp_remainder,
  output logic                        core_start,
  output logic [DATA_WIDTH-1:0]       core_dividend,
  output logic [DATA_WIDTH-1:0]       core_divisor,
  output logic [CLZ_W-1:0]            core_dividend_clz,
  output logic [CLZ_W-1:0]            core_divisor_clz,
  output logic                        core_divisor_is_zero,
  input  logic                        core_done,
  input  logic [DATA_WIDTH-1:0]       core_quotient,
  input  logic [DATA_WIDTH-1:0]       core_remainder,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_last_q;
  logic [IDX_W-1:0]        win_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_quotient_q, rsp_remainder_q;
  logic                    core_start_q;
  logic [DATA_WIDTH-1:0]   core_dividend_q, core_divisor_q;
  logic [CLZ_W-1:0]        core_dividend_clz_q, core_divisor_clz_q;
  logic                    core_divisor_is_zero_q;

  // Round-robin search: first valid requester strictly after rr_last_q.
  logic                    grant_vld_d;
  logic [IDX_W-1:0]        grant_idx_d;
  logic [IDX_W-1:0]        cand;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = rr_last_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_last_q) + k) % NUM_REQ);
      if (!grant_vld_d && req_valid[cand]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand;
      end
    end
  end

  // Operands of the requester that would win this cycle.
  logic [DATA_WIDTH-1:0] sel_dividend, sel_divisor;
  logic [CLZ_W-1:0]      sel_dividend_clz, sel_divisor_clz;
  logic                  sel_divisor_is_zero;

  assign sel_dividend        = req_dividend[int'(grant_idx_d)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_divisor         = req_divisor[int'(grant_idx_d)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_dividend_clz    = req_dividend_clz[int'(grant_idx_d)*CLZ_W +: CLZ_W];
  assign sel_divisor_clz     = req_divisor_clz[int'(grant_idx_d)*CLZ_W +: CLZ_W];
  assign sel_divisor_is_zero = req_divisor_is_zero[grant_idx_d];

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld_d) req_ready[grant_idx_d] = 1'b1;
  end

`ifdef DIV_ARB_REUSE_EN
  logic                  last_valid_q;
  logic [DATA_WIDTH-1:0] last_dividend_q, last_divisor_q;
  logic [DATA_WIDTH-1:0] last_quotient_q, last_remainder_q;
  logic                  reuse_hit;

  assign reuse_hit = last_valid_q && (sel_dividend == last_dividend_q) &&
                     (sel_divisor == last_divisor_q);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                <= S_IDLE;
      rr_last_q              <= IDX_W'(NUM_REQ - 1);
      win_q                  <= '0;
      rsp_valid_q            <= '0;
      rsp_quotient_q         <= '0;
      rsp_remainder_q        <= '0;
      core_start_q           <= 1'b0;
      core_dividend_q        <= '0;
      core_divisor_q         <= '0;
      core_dividend_clz_q    <= '0;
      core_divisor_clz_q     <= '0;
      core_divisor_is_zero_q <= 1'b0;
`ifdef DIV_ARB_REUSE_EN
      // NOTE: the cache contents are reset too, not just the valid bit, so
      // outputs never expose uninitialised data after reset.
      last_valid_q           <= 1'b0;
      last_dividend_q        <= '0;
      last_divisor_q         <= '0;
      last_quotient_q        <= '0;
      last_remainder_q       <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            win_q                  <= grant_idx_d;
            rr_last_q              <= grant_idx_d;
            core_dividend_q        <= sel_dividend;
            core_divisor_q         <= sel_divisor;
            core_dividend_clz_q    <= sel_dividend_clz;
            core_divisor_clz_q     <= sel_divisor_clz;
            core_divisor_is_zero_q <= sel_divisor_is_zero;
`ifdef DIV_ARB_REUSE_EN
            if (reuse_hit) begin
              state_q         <= S_RESP;
              rsp_valid_q     <= NUM_REQ'(1) << grant_idx_d;
              rsp_quotient_q  <= last_quotient_q;
              rsp_remainder_q <= last_remainder_q;
            end else
`endif
            begin
              state_q      <= S_LAUNCH;
              core_start_q <= 1'b1;
            end
          end
        end
        // core_start_q is high for exactly this state.
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            state_q         <= S_RESP;
            rsp_valid_q     <= NUM_REQ'(1) << win_q;
            rsp_quotient_q  <= core_quotient;
            rsp_remainder_q <= core_remainder;
`ifdef DIV_ARB_REUSE_EN
            last_valid_q     <= 1'b1;
            last_dividend_q  <= core_dividend_q;
            last_divisor_q   <= core_divisor_q;
            last_quotient_q  <= core_quotient;
            last_remainder_q <= core_remainder;
`endif
          end
        end
        S_RESP: begin
          // Only the current winner's ack ends the transaction.
          if (rsp_ack[win_q]) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid            = rsp_valid_q;
  assign rsp_quotient         = rsp_quotient_q;
  assign rsp_remainder        = rsp_remainder_q;
  assign core_start           = core_start_q;
  assign core_dividend        = core_dividend_q;
  assign core_divisor         = core_divisor_q;
  assign core_dividend_clz    = core_dividend_clz_q;
  assign core_divisor_clz     = core_divisor_clz_q;
  assign core_divisor_is_zero = core_divisor_is_zero_q;
  assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_core_arbiter
//
// Directed bench for div_core_arbiter with a behavioural div_core (latency 4)
// and a scoreboard: expected results are queued when a request is accepted
// and compared when the arbiter presents a response. Inputs change on the
// falling edge, outputs are sampled shortly after it.
// ---------------------------------------------------------------------------
module tb_div_core_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int CLZ_W   = 5;
  localparam int L       = 4;

`ifdef DIV_ARB_REUSE_EN
  localparam int REPEAT_LAT    = 1;
  localparam int REPEAT_STARTS = 0;
`else
  localparam int REPEAT_LAT    = 6;
  localparam int REPEAT_STARTS = 1;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DW-1:0]     req_dividend = '0;
  logic [NUM_REQ*DW-1:0]     req_divisor = '0;
  logic [NUM_REQ*CLZ_W-1:0]  req_dividend_clz = '0;
  logic [NUM_REQ*CLZ_W-1:0]  req_divisor_clz = '0;
  logic [NUM_REQ-1:0]        req_divisor_is_zero = '0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ack = '0;
  logic [DW-1:0]             rsp_quotient, rsp_remainder;
  logic                      core_start;
  logic [DW-1:0]             core_dividend, core_divisor;
  logic [CLZ_W-1:0]          core_dividend_clz, core_divisor_clz;
  logic                      core_divisor_is_zero;
  logic                      core_done;
  logic [DW-1:0]             core_quotient, core_remainder;
  logic                      busy;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;

  typedef struct {
    int            req;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_core_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_dividend_clz(req_dividend_clz), .req_divisor_clz(req_divisor_clz),
    .req_divisor_is_zero(req_divisor_is_zero),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .core_start(core_start),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_dividend_clz(core_dividend_clz), .core_divisor_clz(core_divisor_clz),
    .core_divisor_is_zero(core_divisor_is_zero),
    .core_done(core_done),
    .core_quotient(core_quotient), .core_remainder(core_remainder),
    .busy(busy)
  );

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == 0) ? '1 : a / b;
  endfunction

  function automatic logic [DW-1:0] ref_r(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic logic [CLZ_W-1:0] clz(input logic [DW-1:0] v);
    logic [CLZ_W-1:0] n = '0;
    bit               f = 1'b0;
    for (int b = DW - 1; b >= 0; b--) begin
      if (!f && v[b]) f = 1'b1;
      else if (!f) n = n + 1'b1;
    end
    return f ? n : '0;
  endfunction

  // Behavioural div_core: done L cycles after start; not reset, so an
  // abandoned operation still produces a stale done pulse.
  logic [L-1:0]  done_sh = '0;
  logic [DW-1:0] m_q = '0, m_r = '0;
  always @(posedge clk) begin
    done_sh <= {done_sh[L-2:0], core_start};
    if (core_start) begin
      m_q       <= ref_q(core_dividend, core_divisor);
      m_r       <= ref_r(core_dividend, core_divisor);
      start_cnt <= start_cnt + 1;
    end
  end
  assign core_done      = done_sh[L-1];
  assign core_quotient  = m_q;
  assign core_remainder = m_r;

  // Scoreboard producer: a transfer happens at the next rising edge.
  always begin
    @(negedge clk);
    #4;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        exp_t e;
        e.req = i;
        e.q   = ref_q(req_dividend[i*DW +: DW], req_divisor[i*DW +: DW]);
        e.r   = ref_r(req_dividend[i*DW +: DW], req_divisor[i*DW +: DW]);
        sb.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_dividend[i*DW +: DW]         = a;
    req_divisor[i*DW +: DW]          = b;
    req_dividend_clz[i*CLZ_W +: CLZ_W] = clz(a);
    req_divisor_clz[i*CLZ_W +: CLZ_W]  = clz(b);
    req_divisor_is_zero[i]           = (b == 0);
    req_valid[i]                     = 1'b1;
  endtask

  // Waits for requester i to be accepted, then drops its valid; returns in
  // the cycle after the accept (core_start cycle for a launched op).
  task automatic wait_accept(input int i, input string tag);
    bit ok = 1'b0;
    #1;
    for (int c = 0; c < 64; c++) begin
      if (req_ready[i]) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    check({tag, "_accept"}, 64'(ok), 64'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    #1;
  endtask

  // Waits for a response, compares it with the scoreboard and acks it.
  task automatic collect(input int exp_req, input string tag);
    bit   seen = 1'b0;
    exp_t e;
    for (int c = 0; c < 64; c++) begin
      if (rsp_valid != 0) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    check({tag, "_rsp_seen"}, 64'(seen), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(NUM_REQ'(1) << exp_req));
      check({tag, "_winner"}, 64'(e.req), 64'(exp_req));
      check({tag, "_quotient"}, 64'(rsp_quotient), 64'(e.q));
      check({tag, "_remainder"}, 64'(rsp_remainder), 64'(e.r));
      rsp_ack = rsp_valid;
      @(negedge clk);
      rsp_ack = '0;
      #1;
      check({tag, "_rsp_cleared"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    int bad;
    int sc;
    int lat;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_quotient", 64'(rsp_quotient), 64'd0);

    // Test 1: 100/7 from req0, latency and single launch pulse
    @(negedge clk);
    rst = 1'b1;
    send(0, 100, 7);
    #1;
    check("t1_ready", 64'(req_ready), 64'b01);
    sc = start_cnt;
    wait_accept(0, "t1");
    check("t1_core_start", 64'(core_start), 64'd1);
    check("t1_core_dividend", 64'(core_dividend), 64'd100);
    check("t1_core_divisor", 64'(core_divisor), 64'd7);
    check("t1_dividend_clz", 64'(core_dividend_clz), 64'd25);
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk); #1;
      check("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
      check("t1_start_single", 64'(core_start), 64'd0);
    end
    @(negedge clk); #1;
    check("t1_rsp_at_T6", 64'(rsp_valid), 64'b01);
    check("t1_q14", 64'(rsp_quotient), 64'd14);
    check("t1_r2", 64'(rsp_remainder), 64'd2);
    rsp_ack = 2'b10;
    @(negedge clk);
    rsp_ack = '0;
    #1;
    check("t1_wrong_ack_ignored", 64'(rsp_valid), 64'b01);

    // Test 3: response held 20 cycles while req1 waits
    send(1, 9, 2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b01 || rsp_quotient !== 32'd14 || rsp_remainder !== 32'd2 ||
          req_ready !== 2'b00 || core_start !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("t3_hold_bad_cycles", 64'(bad), 64'd0);
    check("t3_no_start", 64'(start_cnt - sc), 64'd1);
    collect(0, "t3_req0");
    wait_accept(1, "t3_req1");
    collect(1, "t3_req1");

    // Test 2: both requesters held after reset, grant order 0,1,0,1
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(0, 10, 3);
    send(1, 50, 6);
    #1;
    check("t2_first_ready", 64'(req_ready), 64'b01);
    collect(0, "t2_op0");
    collect(1, "t2_op1");
    collect(0, "t2_op2");
    collect(1, "t2_op3");
    req_valid = '0;

    // Test 4: reset during WAIT, stale core_done ignored
    @(negedge clk);
    send(0, 20, 3);
    sc = start_cnt;
    wait_accept(0, "t4");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    check("t4_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_core_start", 64'(core_start), 64'd0);
    check("t4_rst_core_dividend", 64'(core_dividend), 64'd0);
    check("t4_rst_rsp_quotient", 64'(rsp_quotient), 64'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (rsp_valid !== '0 || busy !== 1'b0 || core_start !== 1'b0) bad++;
    end
    check("t4_stale_done_ignored", 64'(bad), 64'd0);
    check("t4_single_start", 64'(start_cnt - sc), 64'd1);
    send(1, 1000, 33);
    send(0, 7, 7);
    #1;
    check("t4_req0_first", 64'(req_ready), 64'b01);
    wait_accept(0, "t4_req0");
    collect(0, "t4_req0");
    wait_accept(1, "t4_req1");
    collect(1, "t4_req1");

    // Test 5: divide by zero flag passes through
    @(negedge clk);
    send(1, 5, 0);
    wait_accept(1, "t5");
    check("t5_core_start", 64'(core_start), 64'd1);
    check("t5_is_zero", 64'(core_divisor_is_zero), 64'd1);
    check("t5_core_divisor", 64'(core_divisor), 64'd0);
    check("t5_dividend_clz", 64'(core_dividend_clz), 64'd29);
    collect(1, "t5");

    // Test 6: identical operation back-to-back
    @(negedge clk);
    send(0, 100, 7);
    wait_accept(0, "t6_first");
    collect(0, "t6_first");
    sc = start_cnt;
    send(0, 100, 7);
    wait_accept(0, "t6_second");
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid != 0) break;
      @(negedge clk); #1;
      lat++;
    end
    check("t6_latency", 64'(lat), 64'(REPEAT_LAT));
    collect(0, "t6_second");
    check("t6_starts", 64'(start_cnt - sc), 64'(REPEAT_STARTS));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
